// File: rtl/lc3b_types.sv
// Shared LC-3b types: performance-counter select type and event index map.
package lc3b_types;

    typedef logic [2:0] lc3b_perf_sel;

    localparam lc3b_perf_sel PERF_INSTR   = 3'd0;
    localparam lc3b_perf_sel PERF_NOP     = 3'd1;
    localparam lc3b_perf_sel PERF_IC_ACC  = 3'd2;
    localparam lc3b_perf_sel PERF_IC_MISS = 3'd3;
    localparam lc3b_perf_sel PERF_DC_ACC  = 3'd4;
    localparam lc3b_perf_sel PERF_DC_MISS = 3'd5;
    localparam lc3b_perf_sel PERF_L2_ACC  = 3'd6;
    localparam lc3b_perf_sel PERF_L2_MISS = 3'd7;

endpackage

// File: rtl/perf_counter.sv
// Single event counter with clear, freeze, sticky overflow and
// selectable saturate/wrap behaviour at all-ones.
module perf_counter
    import lc3b_types::*;
#(
    parameter int CNT_WIDTH = 16,
    parameter int SATURATE  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 inc,
    input  logic                 clear,
    input  logic                 freeze,
    output logic [CNT_WIDTH-1:0] cnt,
    output logic                 ovf
);

    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 ovf_q, ovf_d;

    // Increment by one; at all-ones either hold (saturate) or roll to zero.
    function automatic logic [CNT_WIDTH-1:0] next_count(input logic [CNT_WIDTH-1:0] c);
        if (&c) begin
            return (SATURATE != 0) ? c : '0;
        end
        return c + 1'b1;
    endfunction

    // Next-state: clear beats freeze, freeze beats the event.
    always_comb begin
        cnt_d = cnt_q;
        ovf_d = ovf_q;
        if (clear) begin
            cnt_d = '0;
            ovf_d = 1'b0;
        end else if (!freeze && inc) begin
            cnt_d = next_count(cnt_q);
            if (&cnt_q) begin
                ovf_d = 1'b1;
            end
        end
    end

    // Counter and sticky overflow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            ovf_q <= ovf_d;
        end
    end

    assign cnt = cnt_q;
    assign ovf = ovf_q;

endmodule

// File: rtl/perf_counter_bank.sv
// Bank of event counters with coherent snapshot and a registered,
// one-cycle-latency read port over live or snapshot values.
module perf_counter_bank
    import lc3b_types::*;
#(
    parameter int NUM_CNT   = 8,
    parameter int CNT_WIDTH = 16,
    parameter int SEL_WIDTH = 3,
    parameter int SATURATE  = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NUM_CNT-1:0]   event_i,
    input  logic                 freeze,
    input  logic                 clear,
    input  logic                 snap,
    input  logic                 rd_en,
    input  logic [SEL_WIDTH-1:0] rd_sel,
    input  logic                 rd_snap,
    output logic                 rd_valid,
    output logic [CNT_WIDTH-1:0] rd_data,
    output logic [NUM_CNT-1:0]   ovf,
    output logic                 snap_valid
);

    logic [CNT_WIDTH-1:0] cnt    [NUM_CNT];
    logic [CNT_WIDTH-1:0] snap_q [NUM_CNT];
    logic [CNT_WIDTH-1:0] snap_d [NUM_CNT];
    logic                 snap_valid_q, snap_valid_d;
    logic [CNT_WIDTH-1:0] rd_data_q, rd_data_d;
    logic                 rd_valid_q, rd_valid_d;

    for (genvar g = 0; g < NUM_CNT; g++) begin : g_cnt
        perf_counter #(
            .CNT_WIDTH(CNT_WIDTH),
            .SATURATE (SATURATE)
        ) u_cnt (
            .clk   (clk),
            .reset (reset),
            .inc   (event_i[g]),
            .clear (clear),
            .freeze(freeze),
            .cnt   (cnt[g]),
            .ovf   (ovf[g])
        );
    end

    // Snapshot captures the pre-update live values; clear and freeze do not gate it.
    always_comb begin
        snap_d       = snap_q;
        snap_valid_d = snap_valid_q | snap;
        if (snap) begin
            snap_d = cnt;
        end
    end

    // Read mux: out-of-range selects return zero; rd_data holds while idle.
    always_comb begin
        rd_data_d  = rd_data_q;
        rd_valid_d = rd_en;
        if (rd_en) begin
            rd_data_d = '0;
            for (int i = 0; i < NUM_CNT; i++) begin
                if (rd_sel == SEL_WIDTH'(i)) begin
                    rd_data_d = rd_snap ? snap_q[i] : cnt[i];
                end
            end
        end
    end

    // Snapshot and read-port registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_CNT; i++) begin
                snap_q[i] <= '0;
            end
            snap_valid_q <= 1'b0;
            rd_data_q    <= '0;
            rd_valid_q   <= 1'b0;
        end else begin
            snap_q       <= snap_d;
            snap_valid_q <= snap_valid_d;
            rd_data_q    <= rd_data_d;
            rd_valid_q   <= rd_valid_d;
        end
    end

    assign rd_data    = rd_data_q;
    assign rd_valid   = rd_valid_q;
    assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_perf_counter_bank.sv
// Directed bench for perf_counter_bank: a default bank plus 4-bit saturating,
// 4-bit wrapping and 6-counter variants, all driven from shared stimulus.
module tb_perf_counter_bank;

    logic        clk = 1'b0;
    logic        reset, freeze, clear, snap, rd_en, rd_snap;
    logic [7:0]  event_i;
    logic [2:0]  rd_sel;

    logic        rd_valid_m, snap_valid_m;
    logic [15:0] rd_data_m;
    logic [7:0]  ovf_m;
    logic        rd_valid_s, snap_valid_s;
    logic [3:0]  rd_data_s;
    logic [7:0]  ovf_s;
    logic        rd_valid_w, snap_valid_w;
    logic [3:0]  rd_data_w;
    logic [7:0]  ovf_w;
    logic        rd_valid_n, snap_valid_n;
    logic [15:0] rd_data_n;
    logic [5:0]  ovf_n;

    int checks = 0;
    int errors = 0;

    typedef struct {
        int          id;
        logic [15:0] expv;
        string       tag;
    } rd_exp_t;
    rd_exp_t sb_q[$];

    always #5 clk = ~clk;

    perf_counter_bank #(.NUM_CNT(8), .CNT_WIDTH(16), .SEL_WIDTH(3), .SATURATE(1)) dut_m (
        .clk(clk), .reset(reset), .event_i(event_i), .freeze(freeze), .clear(clear),
        .snap(snap), .rd_en(rd_en), .rd_sel(rd_sel), .rd_snap(rd_snap),
        .rd_valid(rd_valid_m), .rd_data(rd_data_m), .ovf(ovf_m), .snap_valid(snap_valid_m));

    perf_counter_bank #(.NUM_CNT(8), .CNT_WIDTH(4), .SEL_WIDTH(3), .SATURATE(1)) dut_s (
        .clk(clk), .reset(reset), .event_i(event_i), .freeze(freeze), .clear(clear),
        .snap(snap), .rd_en(rd_en), .rd_sel(rd_sel), .rd_snap(rd_snap),
        .rd_valid(rd_valid_s), .rd_data(rd_data_s), .ovf(ovf_s), .snap_valid(snap_valid_s));

    perf_counter_bank #(.NUM_CNT(8), .CNT_WIDTH(4), .SEL_WIDTH(3), .SATURATE(0)) dut_w (
        .clk(clk), .reset(reset), .event_i(event_i), .freeze(freeze), .clear(clear),
        .snap(snap), .rd_en(rd_en), .rd_sel(rd_sel), .rd_snap(rd_snap),
        .rd_valid(rd_valid_w), .rd_data(rd_data_w), .ovf(ovf_w), .snap_valid(snap_valid_w));

    perf_counter_bank #(.NUM_CNT(6), .CNT_WIDTH(16), .SEL_WIDTH(3), .SATURATE(1)) dut_n (
        .clk(clk), .reset(reset), .event_i(event_i[5:0]), .freeze(freeze), .clear(clear),
        .snap(snap), .rd_en(rd_en), .rd_sel(rd_sel), .rd_snap(rd_snap),
        .rd_valid(rd_valid_n), .rd_data(rd_data_n), .ovf(ovf_n), .snap_valid(snap_valid_n));

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Pop the oldest expected read and compare it against the addressed bank.
    task automatic pop_check();
        rd_exp_t     e;
        logic        v;
        logic [15:0] d;
        if (sb_q.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL sb_empty observed=0 expected=1");
            return;
        end
        e = sb_q.pop_front();
        case (e.id)
            1:       begin v = rd_valid_s; d = {12'h000, rd_data_s}; end
            2:       begin v = rd_valid_w; d = {12'h000, rd_data_w}; end
            3:       begin v = rd_valid_n; d = rd_data_n; end
            default: begin v = rd_valid_m; d = rd_data_m; end
        endcase
        chk({e.tag, "_vld"}, 32'(v), 32'd1);
        chk(e.tag, 32'(d), 32'(e.expv));
    endtask

    task automatic rd(input int id, input logic [2:0] sel, input logic sn,
                      input logic [15:0] expv, input string tag);
        rd_exp_t e;
        @(negedge clk);
        rd_en   = 1'b1;
        rd_sel  = sel;
        rd_snap = sn;
        e.id = id; e.expv = expv; e.tag = tag;
        sb_q.push_back(e);
        @(negedge clk);
        rd_en = 1'b0;
        pop_check();
    endtask

    task automatic pulse(input logic [7:0] ev, input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            event_i = ev;
        end
        @(negedge clk);
        event_i = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; freeze = 1'b0; clear = 1'b0; snap = 1'b0;
        rd_en = 1'b0; rd_sel = '0; rd_snap = 1'b0; event_i = 8'hFF;

        // Reset held two cycles with every event active.
        repeat (2) @(negedge clk);
        reset = 1'b0;
        event_i = '0;
        chk("rst_ovf", 32'(ovf_m), 32'd0);
        chk("rst_rd_valid", 32'(rd_valid_m), 32'd0);
        chk("rst_rd_data", 32'(rd_data_m), 32'd0);
        chk("rst_snap_valid", 32'(snap_valid_m), 32'd0);
        for (int i = 0; i < 8; i++) begin
            rd(0, 3'(i), 1'b0, 16'd0, $sformatf("rst_cnt%0d", i));
        end

        // Count and read.
        pulse(8'h08, 5);
        rd(0, 3'd3, 1'b0, 16'd5, "cnt3_five");
        // Read with a simultaneous event returns the pre-update value.
        @(negedge clk);
        event_i = 8'h08; rd_en = 1'b1; rd_sel = 3'd3; rd_snap = 1'b0;
        sb_q.push_back('{0, 16'd5, "cnt3_preupd"});
        @(negedge clk);
        event_i = '0; rd_en = 1'b0;
        pop_check();
        rd(0, 3'd3, 1'b0, 16'd6, "cnt3_six");
        @(negedge clk);
        chk("idle_vld", 32'(rd_valid_m), 32'd0);
        chk("idle_hold", 32'(rd_data_m), 32'd6);

        // Overflow: 17 events on counter 0.
        pulse(8'h01, 17);
        rd(1, 3'd0, 1'b0, 16'd15, "sat_cnt0");
        rd(2, 3'd0, 1'b0, 16'd1, "wrap_cnt0");
        rd(0, 3'd0, 1'b0, 16'd17, "wide_cnt0");
        chk("sat_ovf0", 32'(ovf_s[0]), 32'd1);
        chk("wrap_ovf0", 32'(ovf_w[0]), 32'd1);
        chk("wide_ovf", 32'(ovf_m), 32'd0);

        // Clear racing an event.
        pulse(8'h04, 7);
        rd(0, 3'd2, 1'b0, 16'd7, "cnt2_seven");
        @(negedge clk);
        clear = 1'b1; event_i = 8'h04;
        @(negedge clk);
        clear = 1'b0; event_i = '0;
        rd(0, 3'd2, 1'b0, 16'd0, "clr_race_cnt2");
        chk("clr_ovf2", 32'(ovf_m[2]), 32'd0);
        chk("clr_ovf_sat", 32'(ovf_s), 32'd0);
        rd(0, 3'd0, 1'b0, 16'd0, "clr_cnt0");

        // Snapshot together with clear.
        pulse(8'h02, 9);
        rd(0, 3'd1, 1'b0, 16'd9, "cnt1_nine");
        @(negedge clk);
        snap = 1'b1; clear = 1'b1;
        @(negedge clk);
        snap = 1'b0; clear = 1'b0;
        pulse(8'h02, 4);
        rd(0, 3'd1, 1'b1, 16'd9, "snap_cnt1");
        rd(0, 3'd1, 1'b0, 16'd4, "live_cnt1");
        rd(0, 3'd0, 1'b1, 16'd0, "snap_cnt0");
        chk("snap_valid", 32'(snap_valid_m), 32'd1);

        // Freeze drops events but not snapshots.
        @(negedge clk);
        freeze = 1'b1;
        pulse(8'h02, 3);
        freeze = 1'b0;
        rd(0, 3'd1, 1'b0, 16'd4, "frz_cnt1");
        @(negedge clk);
        freeze = 1'b1; snap = 1'b1; event_i = 8'h02;
        @(negedge clk);
        freeze = 1'b0; snap = 1'b0; event_i = '0;
        rd(0, 3'd1, 1'b1, 16'd4, "frz_snap_cnt1");
        rd(0, 3'd1, 1'b0, 16'd4, "frz_live_cnt1");

        // Out-of-range selects on the six-counter bank.
        rd(3, 3'd1, 1'b0, 16'd4, "n6_cnt1");
        rd(3, 3'd7, 1'b0, 16'd0, "n6_sel7");
        rd(3, 3'd6, 1'b1, 16'd0, "n6_sel6_snap");

        // Clear leaves snapshots and snap_valid alone.
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        rd(0, 3'd1, 1'b1, 16'd4, "clr_keep_snap");
        rd(0, 3'd1, 1'b0, 16'd0, "clr_live_cnt1");
        chk("clr_keep_snap_valid", 32'(snap_valid_m), 32'd1);

        // Reset overrides a simultaneous snap.
        @(negedge clk);
        reset = 1'b1; snap = 1'b1; event_i = 8'hFF;
        @(negedge clk);
        reset = 1'b0; snap = 1'b0; event_i = '0;
        chk("rst2_snap_valid", 32'(snap_valid_m), 32'd0);
        rd(0, 3'd1, 1'b1, 16'd0, "rst2_snap_cnt1");
        rd(0, 3'd3, 1'b0, 16'd0, "rst2_cnt3");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
